tree_psum_accumulator: RTL and testbench
========================================

Name: tree_psum_accumulator

Overview:
- Sits directly downstream of the DW02_tree carry-save adder tree.
- Takes the tree's two signed partial sums and resolves them with a final carry-propagate add.
- Accumulates the resolved sums over a variable-length group of beats delimited by in_last.
- Emits one rounded, shifted, saturated result per group over a valid/ready handshake (dot-product / conv-window finisher).

Parameters:
- IN_W, 25: width of each partial sum; equals the tree's input_width.
- ACC_W, 32: accumulator width, two's complement; requires ACC_W >= IN_W+1.
- OUT_W, 16: result width, two's complement.
- SHIFT, 0: arithmetic right shift applied at output; 0 to ACC_W-1.
- CNT_W, 8: width of the beat counter.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: psum0/psum1/in_last are valid.
- in_ready, out, 1: block accepts an input beat this cycle.
- in_last, in, 1: the beat closes the current group.
- psum0, in, IN_W: tree OUT0, signed.
- psum1, in, IN_W: tree OUT1, signed.
- out_valid, out, 1: result is valid.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, OUT_W: signed result.
- out_sat, out, 1: saturation occurred in the accumulator or the output clamp for this group.
- out_beats, out, CNT_W: number of beats in the group; saturates at 2^CNT_W-1.

Behaviour:
- Reset (rst=1 at edge): all registers clear. After reset: out_valid=0, out_data=0, out_sat=0, out_beats=0, acc=0, s1_valid=0. Reset mid-group discards the partial accumulation; mid-hold it drops the pending result.
- Global enable: en = !(out_valid && !out_ready). in_ready = en. Accept = in_valid && in_ready.
- Stage S1 (when en): s1_sum <= sext(psum0)+sext(psum1) at IN_W+1 bits (exact, never overflows); s1_last <= in_last; s1_valid <= accept.
- Stage S2 (when en && s1_valid):
  - t = acc + sext(s1_sum), saturating at ACC_W bounds; if t clamps, set sticky sat_acc.
  - beat counter increments, saturating.
  - If !s1_last: acc <= t.
  - If s1_last: compute r = (t + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT (round half up, computed at ACC_W+1 bits). Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Load out_data=clamped r, out_sat = sat_acc | clamp, out_beats = count incl. this beat. out_valid <= 1. Then clear acc, sat_acc, and count.
- Output handshake: out_valid drops on out_valid && out_ready, unless a new result loads the same cycle (the S2 load has priority, so back-to-back results stream with no bubble).
- out_data, out_sat, out_beats are stable while out_valid && !out_ready.
- Latency: last beat accepted at cycle N gives out_valid=1 at N+2. Throughput: one beat per cycle; single-beat groups give one result per cycle.
- Stall: while en=0, S1 and S2 hold; in_ready=0; no input is lost.
- State view (derived, no explicit FSM register):
  - EMPTY: acc=0, count=0.
  - ACCUM: count>0.
  - HOLD: out_valid && !out_ready.
  - Transitions: EMPTY->ACCUM on a non-last S1 beat. ACCUM->EMPTY plus result on a last beat. Any state->HOLD when a result is pending and out_ready=0.
- Simultaneous events: in_valid=0 bubbles leave acc unchanged. Release in the same cycle as a new last beat in S2 loads the new result and keeps out_valid=1.

Decomposition:
- Shared package tree_acc_pkg holds:
  - sat_clamp function (width-generic signed clamp).
  - round_shift function.
  - Default widths: IN_W=25, ACC_W=32, OUT_W=16.
- One sub-module, tree_psum_sat_add: a combinational saturating signed adder (ACC_W), used in S2. Instantiate the tree itself outside this block.

Test Plan:
- Single-beat group psum0=5, psum1=-3, last=1 -> 2 cycles later out_valid=1, out_data=2, out_sat=0, out_beats=1.
- Four beats psum0=100, psum1=28, last on the 4th -> out_data=512, out_beats=4; next group starts from 0 (single beat 1,1 gives 2).
- Output clamp: two beats of psum0=20000, psum1=20000 -> out_data=32767, out_sat=1. Negated stimulus -> out_data=-32768, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with inputs streaming -> in_ready=0, out_data stable. After release, subsequent results match the golden model; no beat dropped or duplicated.
- Rounding with SHIFT=4: group sum 24 -> out_data=2; sum -24 -> out_data=-1; sum 7 -> out_data=0; sum 8 -> out_data=1.
- Reset mid-group: 2 beats of (1000,0), then rst=1 for 1 cycle, then single beat (7,0,last) -> out_data=7, out_beats=1; out_valid stays 0 throughout reset.

Source files
------------

// File: rtl/tree_psum_accumulator_pkg.sv
// Shared widths and arithmetic helpers for the DW02_tree partial-sum finisher.
// The helpers work on a 64-bit signed carrier so they stay width-generic.
package tree_acc_pkg;

    localparam int unsigned DEF_IN_W  = 25;
    localparam int unsigned DEF_ACC_W = 32;
    localparam int unsigned DEF_OUT_W = 16;
    localparam int unsigned DEF_SHIFT = 0;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned MAX_W     = 64;

    typedef logic signed [MAX_W-1:0] wide_t;

    typedef struct packed {
        logic  clamped;
        wide_t val;
    } clamp_res_t;

    // Clamp v into the signed range of a w-bit two's complement value.
    function automatic clamp_res_t sat_clamp(input wide_t v, input int unsigned w);
        wide_t      hi;
        wide_t      lo;
        clamp_res_t res;
        hi          = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo          = -hi - wide_t'(1);
        res.clamped = 1'b0;
        res.val     = v;
        if (v > hi) begin
            res.val     = hi;
            res.clamped = 1'b1;
        end else if (v < lo) begin
            res.val     = lo;
            res.clamped = 1'b1;
        end
        return res;
    endfunction

    // Round half up, then arithmetic shift right by sh.
    function automatic wide_t round_shift(input wide_t v, input int unsigned sh);
        wide_t bias;
        bias = '0;
        if (sh > 0) begin
            bias = wide_t'(1) <<< (sh - 1);
        end
        return (v + bias) >>> sh;
    endfunction

endpackage

// File: rtl/tree_psum_accumulator_if.sv
// Input beat and result handshake bundle for tree_psum_accumulator.
interface tree_psum_accumulator_if #(
    parameter int unsigned IN_W  = 25,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CNT_W = 8
);

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic signed [IN_W-1:0]  psum0;
    logic signed [IN_W-1:0]  psum1;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;
    logic [CNT_W-1:0]        out_beats;

    modport slave (
        input  in_valid, in_last, psum0, psum1, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_beats
    );

    modport master (
        output in_valid, in_last, psum0, psum1, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_beats
    );

endinterface

// File: rtl/tree_psum_accumulator_sat_add.sv
// Combinational signed adder that clamps to the W-bit range on overflow.
module tree_psum_sat_add
    import tree_acc_pkg::*;
#(
    parameter int unsigned W = DEF_ACC_W
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o,
    output logic                sat_o
);

    logic signed [W-1:0] raw;

    assign raw = a_i + b_i;

    // Overflow only when both operands share a sign the wrapped sum lost.
    always_comb begin
        sat_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
        sum_o = raw;
        if (sat_o) begin
            sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/tree_psum_accumulator.sv
// Resolves DW02_tree partial sums, accumulates them per in_last-delimited group
// and emits one rounded, shifted, saturated result per group.
module tree_psum_accumulator
    import tree_acc_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned SHIFT = DEF_SHIFT,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input logic                    clk,
    input logic                    rst,
    tree_psum_accumulator_if.slave bus
);

    localparam int unsigned S1_W = IN_W + 1;

    logic                    en;
    logic                    accept;

    logic signed [S1_W-1:0]  s1_sum_q, s1_sum_d;
    logic                    s1_last_q, s1_last_d;
    logic                    s1_valid_q, s1_valid_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    sat_acc_q, sat_acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cnt_inc;

    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;
    logic [CNT_W-1:0]        out_beats_q, out_beats_d;

    logic signed [ACC_W-1:0] s1_ext;
    logic signed [ACC_W-1:0] t;
    logic                    add_sat;
    wide_t                   rounded;
    clamp_res_t              oc;
    logic                    unused_hi;

    // A result stuck in the output register freezes the whole pipe.
    assign en     = !(out_valid_q && !bus.out_ready);
    assign accept = bus.in_valid && en;

    assign s1_ext = ACC_W'(s1_sum_q);

    tree_psum_sat_add #(
        .W(ACC_W)
    ) u_sat_add (
        .a_i  (acc_q),
        .b_i  (s1_ext),
        .sum_o(t),
        .sat_o(add_sat)
    );

    assign rounded   = round_shift(wide_t'(t), SHIFT);
    assign oc        = sat_clamp(rounded, OUT_W);
    assign unused_hi = ^oc.val[MAX_W-1:OUT_W];
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        s1_sum_d    = s1_sum_q;
        s1_last_d   = s1_last_q;
        s1_valid_d  = s1_valid_q;
        acc_d       = acc_q;
        sat_acc_d   = sat_acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_beats_d = out_beats_q;
        if (en) begin
            s1_sum_d   = S1_W'(bus.psum0) + S1_W'(bus.psum1);
            s1_last_d  = bus.in_last;
            s1_valid_d = accept;
            // en with a valid result implies out_ready; a fresh load below wins.
            if (out_valid_q) begin
                out_valid_d = 1'b0;
            end
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    out_data_d  = oc.val[OUT_W-1:0];
                    out_sat_d   = sat_acc_q | add_sat | oc.clamped;
                    out_beats_d = cnt_inc;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    sat_acc_d   = 1'b0;
                    cnt_d       = '0;
                end else begin
                    acc_d     = t;
                    sat_acc_d = sat_acc_q | add_sat;
                    cnt_d     = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sum_q    <= '0;
            s1_last_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            sat_acc_q   <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            s1_sum_q    <= s1_sum_d;
            s1_last_q   <= s1_last_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            sat_acc_q   <= sat_acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_beats = out_beats_q;

endmodule

// File: tb/tb_tree_psum_accumulator.sv
// Self-checking bench: two DUTs (SHIFT=0 and SHIFT=4) against a group-level model.
module tb_tree_psum_accumulator;

    localparam int unsigned IN_W  = 25;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned CNT_W = 8;
    localparam longint ACC_MAX = 64'sd2147483647;
    localparam longint ACC_MIN = -64'sd2147483648;
    localparam longint PMAX    = 64'sd16777215;

    typedef struct {
        longint data;
        bit     sat;
        int     beats;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tree_psum_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) b0 ();
    tree_psum_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) b4 ();

    tree_psum_accumulator #(
        .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(0), .CNT_W(CNT_W)
    ) dut0 (.clk(clk), .rst(rst), .bus(b0));

    tree_psum_accumulator #(
        .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(4), .CNT_W(CNT_W)
    ) dut4 (.clk(clk), .rst(rst), .bus(b4));

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    res_t exp0[$], exp4[$], got0[$], got4[$];
    res_t g0, g4;

    longint m_acc[2];
    bit     m_sat[2];
    int     m_cnt[2];

    // Group-level reference: exact sums, saturate per beat, round/clamp at the end.
    task automatic model_beat(input int d, input longint p0, input longint p1, input bit last);
        longint t, r;
        int     sh;
        res_t   e;
        t = m_acc[d] + p0 + p1;
        if (t > ACC_MAX) begin t = ACC_MAX; m_sat[d] = 1'b1; end
        if (t < ACC_MIN) begin t = ACC_MIN; m_sat[d] = 1'b1; end
        m_cnt[d] = (m_cnt[d] < 255) ? m_cnt[d] + 1 : 255;
        if (!last) begin
            m_acc[d] = t;
        end else begin
            sh = (d == 1) ? 4 : 0;
            r  = t;
            if (sh > 0) r = (t + (64'sd1 <<< (sh - 1))) >>> sh;
            e.sat = m_sat[d];
            if (r > 32767)  begin r = 32767;  e.sat = 1'b1; end
            if (r < -32768) begin r = -32768; e.sat = 1'b1; end
            e.data  = r;
            e.beats = m_cnt[d];
            if (d == 1) exp4.push_back(e); else exp0.push_back(e);
            m_acc[d] = 0; m_sat[d] = 1'b0; m_cnt[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin m_acc[i] = 0; m_sat[i] = 1'b0; m_cnt[i] = 0; end
        end else begin
            if (b0.in_valid && b0.in_ready)
                model_beat(0, longint'(b0.psum0), longint'(b0.psum1), b0.in_last);
            if (b4.in_valid && b4.in_ready)
                model_beat(1, longint'(b4.psum0), longint'(b4.psum1), b4.in_last);
            if (b0.out_valid && b0.out_ready) begin
                g0.data = longint'(b0.out_data); g0.sat = b0.out_sat; g0.beats = int'(b0.out_beats);
                got0.push_back(g0);
            end
            if (b4.out_valid && b4.out_ready) begin
                g4.data = longint'(b4.out_data); g4.sat = b4.out_sat; g4.beats = int'(b4.out_beats);
                got4.push_back(g4);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input bit sel, input longint p0, input longint p1, input bit last);
        int unsigned n    = 0;
        bit          done = 1'b0;
        if (sel) begin
            b4.psum0 = IN_W'(p0); b4.psum1 = IN_W'(p1); b4.in_last = last; b4.in_valid = 1'b1;
        end else begin
            b0.psum0 = IN_W'(p0); b0.psum1 = IN_W'(p1); b0.in_last = last; b0.in_valid = 1'b1;
        end
        while (!done) begin
            @(negedge clk);
            done = sel ? b4.in_ready : b0.in_ready;
            @(posedge clk); #1;
            n++;
            if (!done && n > 400) begin
                $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", n);
                $fatal;
            end
        end
        if (sel) b4.in_valid = 1'b0; else b0.in_valid = 1'b0;
    endtask

    task automatic wait_got(input bit sel, input int n);
        int unsigned c = 0;
        while (((sel ? got4.size() : got0.size()) < n) && c < 2000) begin
            @(posedge clk); #1; c++;
        end
        idle(4);
    endtask

    task automatic clear_q();
        idle(4);
        exp0.delete(); exp4.delete(); got0.delete(); got4.delete();
    endtask

    function automatic res_t peek(input bit sel, input int i);
        res_t r;
        r.data = -999999; r.sat = 1'b0; r.beats = -1;
        if (sel) begin if (i < got4.size()) r = got4[i]; end
        else begin if (i < got0.size()) r = got0[i]; end
        return r;
    endfunction

    function automatic longint rnd_psum();
        case ($urandom_range(0, 2))
            0:       return longint'($urandom_range(0, 400)) - 200;
            1:       return longint'($urandom_range(0, 40000)) - 20000;
            default: return longint'($urandom_range(0, 33554431)) - 16777216;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (b0.out_valid !== 1'b0 || b0.out_data !== '0 || b0.out_sat !== 1'b0 ||
            b0.out_beats !== '0 || b0.in_ready !== 1'b1 || b4.out_valid !== 1'b0) begin
            $display("FAIL reset_state: valid=%0b data=%0d sat=%0b beats=%0d in_ready=%0b, required 0/0/0/0/1",
                     b0.out_valid, b0.out_data, b0.out_sat, b0.out_beats, b0.in_ready);
        end else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_single_latency();
        clear_q();
        b0.psum0 = 25'sd5; b0.psum1 = -25'sd3; b0.in_last = 1'b1; b0.in_valid = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (b0.in_ready !== 1'b1) $display("FAIL single_accept: in_ready=%0b required 1", b0.in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (b0.out_valid !== 1'b0) $display("FAIL latency_n1: out_valid=%0b required 0", b0.out_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (b0.out_valid !== 1'b1 || b0.out_data !== 16'sd2 || b0.out_sat !== 1'b0 || b0.out_beats !== 8'd1)
            $display("FAIL latency_n2: valid=%0b data=%0d sat=%0b beats=%0d, required 1/2/0/1",
                     b0.out_valid, b0.out_data, b0.out_sat, b0.out_beats);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_multi_beat();
        longint ed[2] = '{512, 2};
        int     eb[2] = '{4, 1};
        res_t   r;
        clear_q();
        for (int i = 0; i < 4; i++) send(0, 100, 28, i == 3);
        send(0, 1, 1, 1'b1);
        wait_got(0, 2);
        total_cnt++;
        if (got0.size() != 2) $display("FAIL multi_count: got %0d results, required 2", got0.size());
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            r = peek(0, i);
            total_cnt++;
            if (r.data != ed[i] || r.beats != eb[i] || r.sat != 1'b0)
                $display("FAIL multi_result%0d: data=%0d beats=%0d sat=%0b, required %0d/%0d/0",
                         i, r.data, r.beats, r.sat, ed[i], eb[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_output_clamp();
        longint ed[2] = '{32767, -32768};
        res_t   r;
        clear_q();
        send(0, 20000, 20000, 1'b0);
        send(0, 20000, 20000, 1'b1);
        send(0, -20000, -20000, 1'b0);
        send(0, -20000, -20000, 1'b1);
        wait_got(0, 2);
        total_cnt++;
        if (got0.size() != 2) $display("FAIL clamp_count: got %0d results, required 2", got0.size());
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            r = peek(0, i);
            total_cnt++;
            if (r.data != ed[i] || r.sat != 1'b1 || r.beats != 2)
                $display("FAIL clamp_result%0d: data=%0d sat=%0b beats=%0d, required %0d/1/2",
                         i, r.data, r.sat, r.beats, ed[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_acc_saturation();
        res_t r;
        clear_q();
        for (int i = 0; i < 70; i++) send(0, PMAX, PMAX, 1'b0);
        for (int i = 0; i < 64; i++) send(0, -PMAX, -PMAX, i == 63);
        for (int i = 0; i < 300; i++) send(0, 0, 0, i == 299);
        wait_got(0, 2);
        r = peek(0, 0);
        total_cnt++;
        if (r.data != 127 || r.sat != 1'b1 || r.beats != 134)
            $display("FAIL acc_sticky_sat: data=%0d sat=%0b beats=%0d, required 127/1/134", r.data, r.sat, r.beats);
        else pass_cnt++;
        r = peek(0, 1);
        total_cnt++;
        if (r.data != 0 || r.sat != 1'b0 || r.beats != 255)
            $display("FAIL beat_count_sat: data=%0d sat=%0b beats=%0d, required 0/0/255", r.data, r.sat, r.beats);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        longint t0;
        res_t   r;
        clear_q();
        t0 = $time;
        for (int i = 1; i <= 6; i++) send(0, i, i, 1'b1);
        total_cnt++;
        if (($time - t0) != 60) $display("FAIL b2b_throughput: took %0d time units, required 60", $time - t0);
        else pass_cnt++;
        wait_got(0, 6);
        for (int i = 0; i < 6; i++) begin
            r = peek(0, i);
            total_cnt++;
            if (r.data != 2 * (i + 1) || r.beats != 1 || r.sat != 1'b0)
                $display("FAIL b2b_result%0d: data=%0d beats=%0d, required %0d/1", i, r.data, r.beats, 2 * (i + 1));
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        res_t r;
        clear_q();
        b0.out_ready = 1'b0;
        fork
            begin
                for (int g = 0; g < 6; g++) begin
                    automatic int len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) send(0, rnd_psum(), rnd_psum(), b == len - 1);
                end
            end
            begin
                automatic int unsigned c = 0;
                automatic logic signed [OUT_W-1:0] held;
                @(negedge clk);
                while (!b0.out_valid && c < 200) begin @(negedge clk); c++; end
                held = b0.out_data;
                for (int k = 0; k < 5; k++) begin
                    total_cnt++;
                    if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b1 || b0.out_data !== held)
                        $display("FAIL hold_cycle%0d: in_ready=%0b valid=%0b data=%0d, required 0/1/%0d",
                                 k, b0.in_ready, b0.out_valid, b0.out_data, held);
                    else pass_cnt++;
                    @(negedge clk);
                end
                @(posedge clk); #1;
                b0.out_ready = 1'b1;
            end
        join
        wait_got(0, exp0.size());
        total_cnt++;
        if (got0.size() != exp0.size() || exp0.size() != 6)
            $display("FAIL bp_count: got %0d results, required %0d (6 groups)", got0.size(), exp0.size());
        else pass_cnt++;
        for (int i = 0; i < exp0.size(); i++) begin
            r = peek(0, i);
            total_cnt++;
            if (r.data != exp0[i].data || r.sat != exp0[i].sat || r.beats != exp0[i].beats)
                $display("FAIL bp_result%0d: data=%0d sat=%0b beats=%0d, required %0d/%0b/%0d", i,
                         r.data, r.sat, r.beats, exp0[i].data, exp0[i].sat, exp0[i].beats);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        bit   stop = 1'b0;
        res_t r;
        clear_q();
        fork
            begin
                for (int g = 0; g < 30; g++) begin
                    automatic int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        if ($urandom_range(0, 3) == 0) idle(1);
                        send(0, rnd_psum(), rnd_psum(), b == len - 1);
                    end
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    b0.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                b0.out_ready = 1'b1;
            end
        join
        wait_got(0, exp0.size());
        total_cnt++;
        if (got0.size() != exp0.size() || exp0.size() != 30)
            $display("FAIL rand_count: got %0d results, required %0d (30 groups)", got0.size(), exp0.size());
        else pass_cnt++;
        for (int i = 0; i < exp0.size(); i++) begin
            r = peek(0, i);
            total_cnt++;
            if (r.data != exp0[i].data || r.sat != exp0[i].sat || r.beats != exp0[i].beats)
                $display("FAIL rand_result%0d: data=%0d sat=%0b beats=%0d, required %0d/%0b/%0d", i,
                         r.data, r.sat, r.beats, exp0[i].data, exp0[i].sat, exp0[i].beats);
            else pass_cnt++;
        end
    endtask

    task automatic test_rounding();
        longint in_v[4] = '{24, -24, 7, 8};
        longint ed[4]   = '{2, -1, 0, 1};
        res_t   r;
        clear_q();
        for (int i = 0; i < 4; i++) send(1, in_v[i], 0, 1'b1);
        wait_got(1, 4);
        for (int i = 0; i < 4; i++) begin
            r = peek(1, i);
            total_cnt++;
            if (r.data != ed[i] || r.sat != 1'b0 || r.beats != 1)
                $display("FAIL round_sum%0d: data=%0d sat=%0b, required %0d/0", in_v[i], r.data, r.sat, ed[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (exp4.size() != 4 || exp4[3].data != r.data)
            $display("FAIL round_model: model size %0d last=%0d, dut last=%0d", exp4.size(),
                     (exp4.size() > 3) ? exp4[3].data : -1, r.data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_group();
        res_t r;
        clear_q();
        send(0, 1000, 0, 1'b0);
        send(0, 1000, 0, 1'b0);
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (b0.out_valid !== 1'b0) $display("FAIL rst_mid_valid: out_valid=%0b required 0", b0.out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (b0.out_valid !== 1'b0) $display("FAIL rst_after_valid: out_valid=%0b required 0", b0.out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        send(0, 7, 0, 1'b1);
        wait_got(0, 1);
        r = peek(0, 0);
        total_cnt++;
        if (got0.size() != 1 || r.data != 7 || r.beats != 1 || r.sat != 1'b0)
            $display("FAIL rst_mid_result: n=%0d data=%0d beats=%0d sat=%0b, required 1/7/1/0",
                     got0.size(), r.data, r.beats, r.sat);
        else pass_cnt++;
    endtask

    initial begin
        b0.in_valid = 1'b0; b0.in_last = 1'b0; b0.psum0 = '0; b0.psum1 = '0; b0.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.in_last = 1'b0; b4.psum0 = '0; b4.psum1 = '0; b4.out_ready = 1'b1;
        test_reset();
        test_single_latency();
        test_multi_beat();
        test_output_clamp();
        test_acc_saturation();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_rounding();
        test_reset_mid_group();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
